alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_pkg.sv | 16 +
 rtl/alu_seq_ctrl_addsub.sv | 21 ++
 rtl/alu_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the sequential add/sub/multiply unit.
package alu_seq_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDSUB = 2'd1,
    S_MUL    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_addsub.sv
// 8-bit adder/subtractor; cin=1 inverts b so the same carry chain yields a - b.
module AddSub_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       overflow
);

  logic [7:0] w_b;
  logic [8:0] w_sum;

  assign w_b   = b ^ {8{cin}};
  assign w_sum = {1'b0, a} + {1'b0, w_b} + {8'd0, cin};
  assign s     = w_sum[7:0];
  assign cout  = w_sum[8];
  // Signed overflow: both addends share a sign that the sum does not.
  assign overflow = (a[7] == w_b[7]) && (s[7] != a[7]);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer that runs ADD/SUB in one step and unsigned MUL as 8 shift-add steps,
// all through a single shared AddSub_8bit.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        overflow,
  output logic        zero,
  output logic        err
);

  state_t      r_state, w_next;
  logic [7:0]  r_a, r_b, r_hi, r_lo, r_s;
  logic [1:0]  r_op;
  logic        r_c, r_v;
  logic [2:0]  r_cnt;
  logic        r_done, r_cout, r_ovf, r_err;
  logic [15:0] r_result;

  logic        w_accept;
  logic [7:0]  w_add_a, w_add_b, w_sum;
  logic        w_add_cin, w_cout, w_ovf;

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_SUB: w_next = S_ADDSUB;
            OP_MUL:         w_next = S_MUL;
            default:        w_next = S_DONE;
          endcase
        end
      end
      S_ADDSUB: w_next = S_DONE;
      S_MUL:    if (r_cnt == 3'd7) w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Adder operand steering: MUL accumulates into hi, otherwise the latched operands.
  always_comb begin
    w_add_a   = r_a;
    w_add_b   = r_b;
    w_add_cin = r_op[0];
    if (r_state == S_MUL) begin
      w_add_a   = r_hi;
      w_add_b   = r_lo[0] ? r_a : 8'h00;
      w_add_cin = 1'b0;
    end
  end

  AddSub_8bit u_addsub (
    .a        (w_add_a),
    .b        (w_add_b),
    .cin      (w_add_cin),
    .s        (w_sum),
    .cout     (w_cout),
    .overflow (w_ovf)
  );

  // Datapath registers: operands, step results and the {hi, lo} product shifter.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= op;
      r_hi <= 8'h00;
      r_lo <= b;
    end
    if (r_state == S_ADDSUB) begin
      r_s <= w_sum;
      r_c <= w_cout;
      r_v <= w_ovf;
    end
    if (r_state == S_MUL) begin
      r_hi <= {w_cout, w_sum[7:1]};
      r_lo <= {w_sum[0], r_lo[7:1]};
    end
  end

  // Control and visible outputs; outputs update on leaving DONE, alongside the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_result <= 16'h0000;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 3'd0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_accept) begin
        r_err <= 1'b0;
        r_cnt <= 3'd0;
      end
      if (r_state == S_MUL) r_cnt <= r_cnt + 3'd1;
      if (r_state == S_DONE) begin
        case (r_op)
          OP_RSV: begin
            r_result <= 16'h0000;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b1;
          end
          OP_MUL: begin
            r_result <= {r_hi, r_lo};
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
          end
          default: begin
            r_result <= {8'h00, r_s};
            r_cout   <= r_c;
            r_ovf    <= r_v;
          end
        endcase
      end
    end
  end

  assign busy     = (r_state == S_ADDSUB) || (r_state == S_MUL);
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;
  assign zero     = (r_result == 16'h0000);
  assign err      = r_err;

endmodule
